alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one `alu_top` instance among NUM_REQ independent requesters.
- Each requester holds at most one operation in flight. The block picks one requester per cycle by round-robin, drives the ALU operand and opcode inputs, and tracks the ALU's registered latency with a tag pipeline.
- It captures each result and zero flag into a per-requester response slot, then returns it over a valid/ready handshake.
- Sits between execution clients (issue slots, test sequencers) and the ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_LATENCY, 1, cycles from ALU input to registered ALU output.
- IDX_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk_i  in  1  clock; also drives the ALU.
- rst_i  in  1  synchronous active-high reset; the same net drives the ALU.
- req_valid_i  in  NUM_REQ  operation request, one bit per requester.
- req_ready_o  out  NUM_REQ  grant; one-hot or zero.
- req_dataA_i  in  NUM_REQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_dataB_i  in  NUM_REQ*32  operand B, same packing.
- req_ctrl_i  in  NUM_REQ*3  ALU opcode, packed the same way.
- rsp_valid_o  out  NUM_REQ  response slot full.
- rsp_ready_i  in  NUM_REQ  response accept.
- rsp_result_o  out  NUM_REQ*32  captured result.
- rsp_zero_o  out  NUM_REQ  captured zero flag.
- rsp_err_o  out  NUM_REQ  opcode was illegal (3'b101).
- alu_dataA_o  out  32  to ALU dataA_i.
- alu_dataB_o  out  32  to ALU dataB_i.
- alu_ctrl_o  out  3  to ALU ALUCtrl_i.
- alu_result_i  in  32  from ALU ALUResult_o.
- alu_zero_i  in  1  from ALU Zero_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high; it is sampled only on the clk_i rising edge.
- Reset values:
  - req_ready_o=0, rsp_valid_o=0, rsp_result_o=0, rsp_zero_o=0, rsp_err_o=0.
  - Tag pipeline cleared; RR pointer=0, so requester 0 has highest priority.
  - ALU outputs are the idle values.
- Reset mid-operation: in-flight tags and full slots are discarded with no response. Requests present during reset are not granted.
- Eligibility: requester i is eligible when req_valid_i[i]=1, its slot is empty, and no tag in the pipeline carries index i.
- Grant: combinational round-robin over eligible requesters, starting at the pointer.
  - req_ready_o[i]=1 for the winner only. Transfer occurs when valid and ready are both high in the same cycle.
  - The pointer becomes (winner+1) mod NUM_REQ on a grant and holds otherwise.
- ALU drive:
  - Granted cycle: alu_* outputs are the winner's operands and opcode, muxed combinationally.
  - No grant: alu_dataA_o=0, alu_dataB_o=0, alu_ctrl_o=3'b000.
- Requester-side rule: once req_valid_i is asserted, it and its payload stay stable until granted.
- Tag pipeline: ALU_LATENCY stages of {vld, idx, err}.
  - Stage 0 loads on grant, with err=(opcode==3'b101).
  - A tag issued in cycle N reaches the last stage in cycle N+ALU_LATENCY. In that cycle alu_result_i and alu_zero_i belong to that tag.
- Capture: when the last-stage tag is valid, slot[idx] loads result, zero and err at that clock edge. rsp_valid_o[idx] rises in cycle N+ALU_LATENCY+1.
- Response: the slot holds its value until rsp_valid_o[i] and rsp_ready_i[i] are both high, then clears at that edge.
  - rsp_result_o, rsp_zero_o and rsp_err_o hold their last values after the pop.
  - rsp_ready_i with an empty slot has no effect.
- Simultaneous events:
  - A pop and an eligibility check for the same requester in the same cycle: the slot counts as still full, so no grant that cycle.
  - A capture into slot i cannot coincide with a full slot i; eligibility guarantees this. The bench asserts it.
- Throughput:
  - One grant per cycle aggregate.
  - Per requester, with immediate pop: grant at N, rsp_valid at N+2, pop at N+2, next grant at N+3 (ALU_LATENCY=1).
- Illegal opcode (101): still issued. The ALU returns result 0; the response carries err=1 with the ALU's zero value passed through.

Decomposition:
- Shared package `alu_pkg`:
  - Opcode enum alu_op_e: ADD=010, SUB=110, AND=000, OR=001, XOR=011, NOR=100, SLT=111, ILLEGAL=101.
  - ALU_W=32.
  - Typedef alu_tag_t {vld, idx, err}.
- Sub-module: `rr_pick`, a parameterized round-robin priority picker. Inputs: eligible vector and pointer. Outputs: one-hot grant and winner index.

Test Plan:
- Reset/idle: hold rst_i 2 cycles with all req_valid_i=1. Required: no grant, all rsp_valid_o=0 and alu_ctrl_o=000. After release, requester 0 is granted first.
- Single op: req1 ADD A=5 B=7 granted at cycle N. Required: alu_ctrl_o=010 at N; rsp_valid_o[1]=1 at N+2 with result=12 and zero=0.
- Fairness: all 4 requesters assert continuously with SUB A=B=3 and pop immediately. Required: grant order 0,1,2,3,0…; every response has result=0, zero=1.
- Backpressure: req2 holds rsp_ready_i=0. Required: slot 2 holds its value, req2 is not regranted and the others keep rotating. Releasing the pop lets req2 be granted 1 cycle later.
- Illegal and SLT: req3 issues op 101. Required: err=1, result=0. Then SLT A=1 B=2 gives result=1, err=0.
- Reset with an op in flight: assert rst_i one cycle after a grant. Required: no rsp_valid_o for the dropped op and the pointer returns to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath width and the tag
// record that follows an operation through the ALU's registered latency.
package alu_pkg;

  localparam int ALU_W     = 32;
  // Tag index width covers the largest supported requester count (8).
  localparam int TAG_IDX_W = 3;

  typedef enum logic [2:0] {
    AND     = 3'b000,
    OR      = 3'b001,
    ADD     = 3'b010,
    XOR     = 3'b011,
    NOR     = 3'b100,
    ILLEGAL = 3'b101,
    SUB     = 3'b110,
    SLT     = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic                 vld;
    logic [TAG_IDX_W-1:0] idx;
    logic                 err;
  } alu_tag_t;

  function automatic logic is_illegal(input logic [2:0] op);
    return op == ILLEGAL;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: the lowest eligible index at or above the
// pointer wins; if none, the lowest eligible index overall wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic hit;

  // Two scans: first the upper window starting at the pointer, then wrap.
  always_comb begin
    grant  = '0;
    winner = '0;
    hit    = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!hit && eligible[j] && (j >= int'(ptr))) begin
        hit      = 1'b1;
        grant[j] = 1'b1;
        winner   = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!hit && eligible[j]) begin
        hit      = 1'b1;
        grant[j] = 1'b1;
        winner   = IW'(j);
      end
    end
    found = hit;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one registered ALU among NUM_REQ requesters. A round-robin pick
// drives the ALU each cycle, a tag pipeline follows the ALU latency, and
// each result lands in a per-requester slot returned over valid/ready.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*ALU_W-1:0] req_dataA_i,
  input  logic [NUM_REQ*ALU_W-1:0] req_dataB_i,
  input  logic [NUM_REQ*3-1:0]     req_ctrl_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [NUM_REQ*ALU_W-1:0] rsp_result_o,
  output logic [NUM_REQ-1:0]       rsp_zero_o,
  output logic [NUM_REQ-1:0]       rsp_err_o,
  output logic [ALU_W-1:0]         alu_dataA_o,
  output logic [ALU_W-1:0]         alu_dataB_o,
  output logic [2:0]               alu_ctrl_o,
  input  logic [ALU_W-1:0]         alu_result_i,
  input  logic                     alu_zero_i
);

  alu_tag_t           tag_q [ALU_LATENCY];
  alu_tag_t           issue_tag;
  alu_tag_t           last_tag;
  logic [NUM_REQ-1:0] slot_full;
  logic [NUM_REQ-1:0] in_flight;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   winner;
  logic               found;

  assign last_tag    = tag_q[ALU_LATENCY-1];
  assign rsp_valid_o = slot_full;
  assign req_ready_o = grant;

  // A requester is busy while any tag in the ALU pipeline carries its index.
  always_comb begin
    in_flight = '0;
    for (int s = 0; s < ALU_LATENCY; s++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tag_q[s].vld && (tag_q[s].idx == TAG_IDX_W'(i))) begin
          in_flight[i] = 1'b1;
        end
      end
    end
  end

  // A slot being popped this cycle still counts as full, so no same-cycle regrant.
  assign eligible = rst_i ? '0 : (req_valid_i & ~slot_full & ~in_flight);

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .winner   (winner),
    .found    (found)
  );

  // Steer the winner's operands to the ALU; idle zeros when nobody wins.
  always_comb begin
    alu_dataA_o = '0;
    alu_dataB_o = '0;
    alu_ctrl_o  = 3'b000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_dataA_o = req_dataA_i[i*ALU_W +: ALU_W];
        alu_dataB_o = req_dataB_i[i*ALU_W +: ALU_W];
        alu_ctrl_o  = req_ctrl_i[i*3 +: 3];
      end
    end
  end

  // Build the tag entering the pipeline alongside the ALU operands.
  always_comb begin
    issue_tag = '0;
    if (found) begin
      issue_tag.vld = 1'b1;
      issue_tag.idx = TAG_IDX_W'(winner);
      issue_tag.err = is_illegal(alu_ctrl_o);
    end
  end

  // Shift tags in lockstep with the ALU's internal registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < ALU_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= issue_tag;
      for (int s = 1; s < ALU_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Advance the round-robin pointer past the winner on every grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    end
  end

  // Capture the ALU output into the tagged slot; clear a slot on pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_full    <= '0;
      rsp_result_o <= '0;
      rsp_zero_o   <= '0;
      rsp_err_o    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_tag.vld && (last_tag.idx == TAG_IDX_W'(i))) begin
          slot_full[i]                   <= 1'b1;
          rsp_result_o[i*ALU_W +: ALU_W] <= alu_result_i;
          rsp_zero_o[i]                  <= alu_zero_i;
          rsp_err_o[i]                   <= last_tag.err;
        end else if (slot_full[i] && rsp_ready_i[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural one-cycle ALU.
module tb_alu_rr_arbiter;

  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*32-1:0] req_a;
  logic [NR*32-1:0] req_b;
  logic [NR*3-1:0]  req_ctrl;
  logic [NR-1:0]  rsp_valid;
  logic [NR-1:0]  rsp_ready;
  logic [NR*32-1:0] rsp_result;
  logic [NR-1:0]  rsp_zero;
  logic [NR-1:0]  rsp_err;
  logic [31:0]    alu_a;
  logic [31:0]    alu_b;
  logic [2:0]     alu_ctrl;
  logic [31:0]    alu_result;
  logic           alu_zero;

  int total = 0;
  int bad   = 0;

  logic [3:0]  exp_grant [0:15];
  logic [2:0]  t_op   [0:3];
  logic [31:0] t_a    [0:3];
  logic [31:0] t_b    [0:3];
  logic [31:0] t_res  [0:3];
  logic        t_zero [0:3];
  logic        t_err  [0:3];
  logic [3:0]  start_valid;
  logic [3:0]  start_ready;
  logic [3:0]  grant_d = 4'b0000;

  alu_rr_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_dataA_i  (req_a),
    .req_dataB_i  (req_b),
    .req_ctrl_i   (req_ctrl),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .rsp_err_o    (rsp_err),
    .alu_dataA_o  (alu_a),
    .alu_dataB_o  (alu_b),
    .alu_ctrl_o   (alu_ctrl),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] aluRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b011:  return a ^ b;
      3'b100:  return ~(a | b);
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Registered ALU stand-in with one cycle of latency.
  always @(posedge clk) begin
    if (rst) begin
      alu_result <= 32'd0;
      alu_zero   <= 1'b0;
    end else begin
      alu_result <= aluRef(alu_ctrl, alu_a, alu_b);
      alu_zero   <= (aluRef(alu_ctrl, alu_a, alu_b) == 32'd0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // A grant last cycle must never land on a slot that is still full.
  always @(negedge clk) begin
    #2;
    if (grant_d != 4'b0000) checkOutput("capture_into_full", 32'(grant_d & rsp_valid), 32'd0);
    grant_d <= req_ready;
  end

  task automatic applyStimulus(input int idx, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] want_res,
                               input logic want_zero, input logic want_err, input int hold);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    @(negedge clk);
    req_a[idx*32 +: 32]  = a;
    req_b[idx*32 +: 32]  = b;
    req_ctrl[idx*3 +: 3] = op;
    req_valid            = onehot;
    rsp_ready            = 4'b1111;
    rsp_ready[idx]       = (hold == 0);
    #1;
    checkOutput("op_grant", 32'(req_ready), 32'(onehot));
    checkOutput("op_ctrl", 32'(alu_ctrl), 32'(op));
    checkOutput("op_dataA", alu_a, a);
    checkOutput("op_dataB", alu_b, b);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checkOutput("op_alu_idle", 32'(alu_ctrl), 32'd0);
    checkOutput("op_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("op_rsp_valid", 32'(rsp_valid), 32'(onehot));
    checkOutput("op_result", rsp_result[idx*32 +: 32], want_res);
    checkOutput("op_zero", 32'(rsp_zero[idx]), 32'(want_zero));
    checkOutput("op_err", 32'(rsp_err[idx]), 32'(want_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (h == hold - 1) rsp_ready = 4'b1111;
      #1;
      checkOutput("op_hold_valid", 32'(rsp_valid), 32'(onehot));
      checkOutput("op_hold_result", rsp_result[idx*32 +: 32], want_res);
    end
    @(negedge clk);
    #1;
    checkOutput("op_popped", 32'(rsp_valid), 32'd0);
    checkOutput("op_result_kept", rsp_result[idx*32 +: 32], want_res);
    rsp_ready = 4'b1111;
  endtask

  task automatic runTable(input int n, input int clear_from, input int release_at,
                          input bit timing_chk, input int held_idx, input int exp_pops);
    int pops;
    pops = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) begin
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
          req_a[i*32 +: 32]  = t_a[i];
          req_b[i*32 +: 32]  = t_b[i];
          req_ctrl[i*3 +: 3] = t_op[i];
        end
        req_valid = start_valid;
        rsp_ready = start_ready;
      end
      if (c >= clear_from) req_valid = req_valid & ~exp_grant[c-1];
      if (c == release_at) rsp_ready = 4'b1111;
      #1;
      checkOutput("grant_order", 32'(req_ready), 32'(exp_grant[c]));
      for (int i = 0; i < NR; i++) begin
        if (exp_grant[c][i]) begin
          checkOutput("alu_ctrl", 32'(alu_ctrl), 32'(t_op[i]));
          checkOutput("alu_dataA", alu_a, t_a[i]);
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i]) begin
          checkOutput("rsp_result", rsp_result[i*32 +: 32], t_res[i]);
          checkOutput("rsp_zero", 32'(rsp_zero[i]), 32'(t_zero[i]));
          checkOutput("rsp_err", 32'(rsp_err[i]), 32'(t_err[i]));
        end
      end
      if (timing_chk)
        checkOutput("rsp_timing", 32'(rsp_valid), (c >= 2) ? 32'(exp_grant[c-2]) : 32'd0);
      else if (c >= 2 && c <= release_at)
        checkOutput("held_slot", 32'(rsp_valid[held_idx]), 32'd1);
      pops += $countones(rsp_valid & rsp_ready);
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      #1;
      checkOutput("drain_grant", 32'(req_ready), 32'd0);
      pops += $countones(rsp_valid & rsp_ready);
    end
    checkOutput("pop_count", 32'(pops), 32'(exp_pops));
    checkOutput("drained", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;

    // Reset with every requester asking, followed by fairness (SUB 3-3).
    for (int i = 0; i < NR; i++) begin
      t_op[i] = 3'b110; t_a[i] = 32'd3; t_b[i] = 32'd3;
      t_res[i] = 32'd0; t_zero[i] = 1'b1; t_err[i] = 1'b0;
      req_a[i*32 +: 32] = 32'd3; req_b[i*32 +: 32] = 32'd3; req_ctrl[i*3 +: 3] = 3'b110;
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("reset_grant", 32'(req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_alu_ctrl", 32'(alu_ctrl), 32'd0);
      checkOutput("reset_result", rsp_result[31:0], 32'd0);
    end
    exp_grant[0] = 4'b0001; exp_grant[1] = 4'b0010; exp_grant[2] = 4'b0100; exp_grant[3] = 4'b1000;
    exp_grant[4] = 4'b0001; exp_grant[5] = 4'b0010; exp_grant[6] = 4'b0100; exp_grant[7] = 4'b1000;
    exp_grant[8] = 4'b0000; exp_grant[9] = 4'b0000;
    start_valid = 4'b1111;
    start_ready = 4'b1111;
    runTable(10, 5, 0, 1'b1, 0, 8);

    // Single ADD on requester 1, response held one extra cycle.
    applyStimulus(1, 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1);

    // Backpressure on requester 2 while the others rotate.
    t_op[0] = 3'b010; t_a[0] = 32'h1;  t_b[0] = 32'h1;  t_res[0] = 32'h2;        t_zero[0] = 1'b0; t_err[0] = 1'b0;
    t_op[1] = 3'b011; t_a[1] = 32'hF0; t_b[1] = 32'hFF; t_res[1] = 32'h0F;       t_zero[1] = 1'b0; t_err[1] = 1'b0;
    t_op[2] = 3'b001; t_a[2] = 32'hC;  t_b[2] = 32'hA;  t_res[2] = 32'hE;        t_zero[2] = 1'b0; t_err[2] = 1'b0;
    t_op[3] = 3'b100; t_a[3] = 32'h0;  t_b[3] = 32'h0;  t_res[3] = 32'hFFFFFFFF; t_zero[3] = 1'b0; t_err[3] = 1'b0;
    exp_grant[0]  = 4'b0100; exp_grant[1]  = 4'b1000; exp_grant[2]  = 4'b0001; exp_grant[3]  = 4'b0010;
    exp_grant[4]  = 4'b1000; exp_grant[5]  = 4'b0001; exp_grant[6]  = 4'b0010; exp_grant[7]  = 4'b1000;
    exp_grant[8]  = 4'b0001; exp_grant[9]  = 4'b0010; exp_grant[10] = 4'b0100; exp_grant[11] = 4'b1000;
    exp_grant[12] = 4'b0001; exp_grant[13] = 4'b0010; exp_grant[14] = 4'b0000;
    start_valid = 4'b1111;
    start_ready = 4'b1011;
    runTable(15, 11, 9, 1'b0, 2, 14);

    // Illegal opcode then SLT on requester 3.
    applyStimulus(3, 3'b101, 32'd9, 32'd4, 32'd0, 1'b1, 1'b1, 0);
    applyStimulus(3, 3'b111, 32'd1, 32'd2, 32'd1, 1'b0, 1'b0, 0);

    // Reset one cycle after a grant: op dropped and pointer back to 0.
    @(negedge clk);
    req_a[63:32] = 32'd5; req_b[63:32] = 32'd7; req_ctrl[5:3] = 3'b010;
    req_valid = 4'b0010;
    #1;
    checkOutput("rst_pre_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    rst       = 1'b1;
    #1;
    checkOutput("rst_mid_grant", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_a[31:0]   = 32'd1; req_b[31:0]   = 32'd1; req_ctrl[2:0]  = 3'b010;
    req_a[127:96] = 32'd0; req_b[127:96] = 32'd0; req_ctrl[11:9] = 3'b100;
    req_valid = 4'b1001;
    #1;
    checkOutput("rst_ptr_zero", 32'(req_ready), 32'h1);
    checkOutput("rst_dropped", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    checkOutput("rst_next_grant", 32'(req_ready), 32'h8);
    checkOutput("rst_dropped2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checkOutput("rst_rsp0", 32'(rsp_valid), 32'h1);
    checkOutput("rst_rsp0_result", rsp_result[31:0], 32'd2);
    @(negedge clk);
    #1;
    checkOutput("rst_rsp3", 32'(rsp_valid), 32'h8);
    checkOutput("rst_rsp3_result", rsp_result[127:96], 32'hFFFFFFFF);
    @(negedge clk);
    #1;
    checkOutput("rst_final_idle", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
